// File: rtl/apb_sram_ws.sv
// rtl/apb_sram_ws.sv - APB4 slave SRAM with wait states, byte strobes and error response
module apb_sram_ws #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);

   localparam int NSTRB = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(NSTRB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NSTRB - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_W    = ADDR_WIDTH'(DEPTH);
   localparam logic [3:0]            WS         = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NSTRB-1:0]      strb_q, strb_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;

   // Contents are deliberately left unreset; only control state is cleared.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  setup_err;
   logic [IDX_W-1:0]      setup_idx;
   logic                  setup_ph;
   logic                  access_ph;
   logic                  commit;

   // Decode the setup-phase address: word index and error (misaligned or beyond DEPTH).
   always_comb begin
      word_addr = paddr >> LSB;
      setup_err = (|(paddr & ALIGN_MASK)) || (word_addr >= DEPTH_W);
      setup_idx = word_addr[IDX_W-1:0];
      setup_ph  = psel & ~penable;
      access_ph = psel & penable;
      commit    = (state_q == S_RESP) & access_ph & write_q & ~err_q;
   end

   // Next-state, latched transfer attributes and registered bus outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      err_d     = err_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      case (state_q)
         S_IDLE: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            if (setup_ph) begin
               write_d = pwrite;
               err_d   = setup_err;
               idx_d   = setup_idx;
               wdata_d = pwdata;
               strb_d  = pstrb;
               if (WS == 4'd0) begin
                  state_d   = S_RESP;
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  prdata_d  = (!pwrite && !setup_err) ? mem[setup_idx] : '0;
               end else begin
                  cnt_d   = WS;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!psel) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (penable) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d   = S_RESP;
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = (!write_q && !err_q) ? mem[idx_q] : '0;
               end
            end
         end
         S_RESP: begin
            // Either completion or abort: both return to IDLE with outputs cleared.
            if (!psel || penable) begin
               state_d   = S_IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cnt_d     = 4'd0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
         end
      endcase
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Byte-lane write commit on the completing access cycle of a good write.
   always_ff @(posedge pclk) begin
      if (commit) begin
         for (int i = 0; i < NSTRB; i++) begin
            if (strb_q[i]) begin
               mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_sram_ws.sv
// tb/tb_apb_sram_ws.sv - directed bench for apb_sram_ws with 0 and 3 wait states
module tb_apb_sram_ws;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [31:0] paddr   [2];
   logic [31:0] pwdata  [2];
   logic [3:0]  pstrb   [2];
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];

   int vecs = 0;
   int miscmp = 0;

   always #5 pclk = ~pclk;

   apb_sram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
      .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

   apb_sram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_dut3 (
      .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

   // One APB transfer; entered and left 1 time unit after a rising edge.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input bit scr,
                       output logic [31:0] rd, output logic er, output int wc,
                       output logic pr_setup);
      wc = 0;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
      paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
      @(negedge pclk);
      pr_setup = pready[d];
      @(posedge pclk); #1;
      penable[d] = 1'b1;
      if (scr) begin
         paddr[d]  = addr ^ 32'h4;
         pwdata[d] = ~data;
         pwrite[d] = ~wr;
      end
      while (wc < 40) begin
         @(negedge pclk);
         if (pready[d]) break;
         wc++;
      end
      rd = prdata[d];
      er = pslverr[d];
      @(posedge pclk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         vecs++; if (pready[d] !== 1'b0) begin miscmp++; $display("FAIL reset_pready[%0d]: got %b expected 0", d, pready[d]); end
         vecs++; if (pslverr[d] !== 1'b0) begin miscmp++; $display("FAIL reset_pslverr[%0d]: got %b expected 0", d, pslverr[d]); end
         vecs++; if (prdata[d] !== 32'h0) begin miscmp++; $display("FAIL reset_prdata[%0d]: got %h expected 0", d, prdata[d]); end
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd; logic er, ps; int wc;
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, wc, ps);
      vecs++; if (wc !== 0) begin miscmp++; $display("FAIL basic_wr_wait: got %0d expected 0", wc); end
      vecs++; if (er !== 1'b0) begin miscmp++; $display("FAIL basic_wr_err: got %b expected 0", er); end
      xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (wc !== 0) begin miscmp++; $display("FAIL basic_rd_wait: got %0d expected 0", wc); end
      vecs++; if (rd !== 32'hDEADBEEF) begin miscmp++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
      vecs++; if (er !== 1'b0) begin miscmp++; $display("FAIL basic_rd_err: got %b expected 0", er); end
   endtask

   task automatic test_strobe();
      logic [31:0] rd; logic er, ps; int wc;
      xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF, 1'b0, rd, er, wc, ps);
      xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 1'b0, rd, er, wc, ps);
      xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'h11BB33DD) begin miscmp++; $display("FAIL strobe_data: got %h expected 11bb33dd", rd); end
      xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (er !== 1'b0) begin miscmp++; $display("FAIL strobe0_err: got %b expected 0", er); end
      xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'h11BB33DD) begin miscmp++; $display("FAIL strobe0_data: got %h expected 11bb33dd", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er, ps; int wc;
      xfer(0, 1'b1, 32'h00, 32'h0BADF00D, 4'hF, 1'b0, rd, er, wc, ps);
      xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (er !== 1'b1) begin miscmp++; $display("FAIL err_rd80_err: got %b expected 1", er); end
      vecs++; if (rd !== 32'h0) begin miscmp++; $display("FAIL err_rd80_data: got %h expected 0", rd); end
      xfer(0, 1'b0, 32'h03, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (er !== 1'b1) begin miscmp++; $display("FAIL err_rd03_err: got %b expected 1", er); end
      vecs++; if (rd !== 32'h0) begin miscmp++; $display("FAIL err_rd03_data: got %h expected 0", rd); end
      xfer(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, wc, ps);
      vecs++; if (er !== 1'b1) begin miscmp++; $display("FAIL err_wr80_err: got %b expected 1", er); end
      xfer(0, 1'b1, 32'h09, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, wc, ps);
      vecs++; if (er !== 1'b1) begin miscmp++; $display("FAIL err_wr09_err: got %b expected 1", er); end
      xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'h0BADF00D) begin miscmp++; $display("FAIL err_word0: got %h expected 0badf00d", rd); end
      xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'hDEADBEEF) begin miscmp++; $display("FAIL err_word2: got %h expected deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er, ps; int wc;
      xfer(0, 1'b1, 32'h0C, 32'h12345678, 4'hF, 1'b0, rd, er, wc, ps);
      xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (ps !== 1'b0) begin miscmp++; $display("FAIL b2b_pready_one_cycle: got %b expected 0", ps); end
      vecs++; if (rd !== 32'h12345678) begin miscmp++; $display("FAIL b2b_data: got %h expected 12345678", rd); end
      vecs++; if (wc !== 0) begin miscmp++; $display("FAIL b2b_wait: got %0d expected 0", wc); end
   endtask

   task automatic test_missing_setup();
      logic [31:0] rd; logic er, ps; int wc;
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
      paddr[0] = 32'h08; pwdata[0] = 32'h0; pstrb[0] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         vecs++; if (pready[0] !== 1'b0) begin miscmp++; $display("FAIL nosetup_pready: got %b expected 0", pready[0]); end
      end
      @(posedge pclk); #1;
      psel[0] = 1'b0; penable[0] = 1'b0;
      xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'hDEADBEEF) begin miscmp++; $display("FAIL nosetup_data: got %h expected deadbeef", rd); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic er, ps; int wc;
      xfer(1, 1'b1, 32'h18, 32'h55AA55AA, 4'hF, 1'b0, rd, er, wc, ps);
      vecs++; if (wc !== 3) begin miscmp++; $display("FAIL ws_wr_wait: got %0d expected 3", wc); end
      xfer(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, wc, ps);
      vecs++; if (wc !== 3) begin miscmp++; $display("FAIL ws_scr_wait: got %0d expected 3", wc); end
      vecs++; if (er !== 1'b0) begin miscmp++; $display("FAIL ws_scr_err: got %b expected 0", er); end
      xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'hCAFEF00D) begin miscmp++; $display("FAIL ws_rd14: got %h expected cafef00d", rd); end
      vecs++; if (wc !== 3) begin miscmp++; $display("FAIL ws_rd_wait: got %0d expected 3", wc); end
      xfer(1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'h55AA55AA) begin miscmp++; $display("FAIL ws_rd18: got %h expected 55aa55aa", rd); end
      xfer(1, 1'b0, 32'h7C, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (er !== 1'b0) begin miscmp++; $display("FAIL ws_last_word_err: got %b expected 0", er); end
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er, ps; int wc;
      xfer(1, 1'b1, 32'h10, 32'h600DCAFE, 4'hF, 1'b0, rd, er, wc, ps);
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = 32'h10; pwdata[1] = 32'hBAD0BAD0; pstrb[1] = 4'hF;
      @(posedge pclk); #1; penable[1] = 1'b1;
      @(posedge pclk); #1; psel[1] = 1'b0; penable[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         vecs++; if (pready[1] !== 1'b0) begin miscmp++; $display("FAIL abort_pready: got %b expected 0", pready[1]); end
      end
      @(posedge pclk); #1;
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'h600DCAFE) begin miscmp++; $display("FAIL abort_data: got %h expected 600dcafe", rd); end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd; logic er, ps; int wc;
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h08;
      @(posedge pclk); #1; penable[0] = 1'b1;
      @(negedge pclk);
      vecs++; if (prdata[0] !== 32'hDEADBEEF) begin miscmp++; $display("FAIL arst_pre_data: got %h expected deadbeef", prdata[0]); end
      #2 presetn = 1'b0;
      #1;
      vecs++; if (pready[0] !== 1'b0) begin miscmp++; $display("FAIL arst_resp_pready: got %b expected 0", pready[0]); end
      vecs++; if (prdata[0] !== 32'h0) begin miscmp++; $display("FAIL arst_resp_prdata: got %h expected 0", prdata[0]); end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(posedge pclk); #1; presetn = 1'b1;
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h14;
      @(posedge pclk); #1; penable[1] = 1'b1;
      @(negedge pclk);
      #2 presetn = 1'b0;
      #1;
      vecs++; if (pready[1] !== 1'b0) begin miscmp++; $display("FAIL arst_wait_pready: got %b expected 0", pready[1]); end
      vecs++; if (pslverr[1] !== 1'b0) begin miscmp++; $display("FAIL arst_wait_pslverr: got %b expected 0", pslverr[1]); end
      vecs++; if (prdata[1] !== 32'h0) begin miscmp++; $display("FAIL arst_wait_prdata: got %h expected 0", prdata[1]); end
      @(posedge pclk); #1; presetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         vecs++; if (pready[1] !== 1'b0) begin miscmp++; $display("FAIL arst_dropped_pready: got %b expected 0", pready[1]); end
      end
      @(posedge pclk); #1; psel[1] = 1'b0; penable[1] = 1'b0;
      xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'hCAFEF00D) begin miscmp++; $display("FAIL arst_after_data: got %h expected cafef00d", rd); end
      vecs++; if (wc !== 3) begin miscmp++; $display("FAIL arst_after_wait: got %0d expected 3", wc); end
      xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, wc, ps);
      vecs++; if (rd !== 32'hDEADBEEF) begin miscmp++; $display("FAIL arst_after_dut0: got %h expected deadbeef", rd); end
   endtask

   initial begin
      presetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      end
      #23;
      test_reset();
      @(posedge pclk); #1; presetn = 1'b1;
      @(posedge pclk); #1;
      test_basic();
      test_strobe();
      test_errors();
      test_back_to_back();
      test_missing_setup();
      test_wait_states();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule

// File: doc/apb_sram_ws.md
# apb_sram_ws

Parametrised APB4 slave SRAM: the next generation of the team's APB RAM slave, with configurable data width, depth and access wait states, byte-lane write strobes, and error response on misaligned or out-of-range access. Sits on the APB peripheral bus behind the bridge as a scratch/test memory and as the reference target for the APB UVM environment.

## Interface
- DATA_WIDTH, 32, bus data width; multiple of 8, 8..64; NSTRB = DATA_WIDTH/8.
- ADDR_WIDTH, 32, paddr width.
- DEPTH, 32, number of DATA_WIDTH words; power of two, 2..1024.
- WAIT_STATES, 0, pready-low access cycles per transfer, 0..15.
- pclk  in  1  bus clock; all logic on rising edge.
- presetn  in  1  reset; one clock domain, asynchronous and active-low.
- psel  in  1  slave select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  NSTRB  write byte-lane enables; ignored on reads.
- prdata  out  DATA_WIDTH  read data; registered; valid only while pready=1 on a read.
- pready  out  1  transfer completion; registered.
- pslverr  out  1  error response; registered; valid only while pready=1.

## Operation
- Word index = paddr >> log2(NSTRB). Error condition ERR = paddr low log2(NSTRB) bits nonzero, or word index >= DEPTH.
- States: IDLE, WAIT, RESP.
- IDLE: outputs pready=0, pslverr=0. On psel=1 & penable=0 (setup): latch pwrite, paddr, pwdata, pstrb; evaluate ERR. WAIT_STATES=0 -> RESP; else load counter=WAIT_STATES -> WAIT.
- WAIT: each cycle with psel=1 & penable=1, counter decrements; on the edge where counter goes 1 -> 0, enter RESP. pready=0 throughout.
- Entering RESP (same edge): pready<=1; pslverr<=ERR; read & !ERR: prdata<=mem[index]; otherwise prdata<=0.
- RESP: on edge with psel=1 & penable=1: write & !ERR commits byte lane i of pwdata_latched to mem[index] for each pstrb_latched[i]=1; pready<=0, pslverr<=0, prdata<=0; -> IDLE.
- ERR write: memory unchanged. pstrb=0 write: completes, no change, pslverr=0.
- Latched attributes govern the transfer; paddr/pwdata/pwrite changes after setup are ignored.
- Protocol abort: psel=0 in WAIT or RESP -> IDLE next edge, outputs cleared, no write committed.
- penable=1 with psel=1 in IDLE (missing setup): ignored, stay IDLE.
- Memory contents are not reset (undefined after power-up); presetn clears only state, counter, and outputs.

## Timing
- Reset (asynchronous assert, synchronous-release use): state=IDLE, counter=0, prdata=0, pready=0, pslverr=0, immediately on presetn falling.
- Setup at cycle N -> pready high in cycle N+1+WAIT_STATES; transfer length = 2+WAIT_STATES cycles.
- Write visible to a read whose setup begins the cycle after completion.
- Back-to-back: a new setup in the cycle immediately after the completing access cycle is accepted (IDLE sees it); no dead cycle required.
- pready high for exactly one cycle per transfer under legal master behaviour.
- Reset mid-transfer: transfer dropped, no write committed; if asserted during the completing cycle, the write may or may not land — verification must not check it.

## Test plan
- Reset, WAIT_STATES=0: write 0xDEADBEEF to 0x08, pstrb=0xF, then read 0x08 -> pready in 2nd cycle of each, prdata=0xDEADBEEF, pslverr=0.
- Byte strobes: write 0x11223344 to 0x04, then 0xAABBCCDD with pstrb=0x5 -> read 0x04 returns 0x11BB33DD.
- Errors: read 0x80 (DEPTH=32) and 0x03 -> pslverr=1, prdata=0; write 0xFFFFFFFF to 0x80 -> pslverr=1, all mem words unchanged.
- WAIT_STATES=3: setup at cycle N -> pready=0 cycles N+1..N+3, pready=1 at N+4; paddr changed during wait ignored.
- Abort: drop psel during WAIT on a write to 0x10 -> IDLE, pready stays 0, read 0x10 returns prior value.
- Async reset asserted mid-WAIT, between clock edges -> pready, pslverr, prdata 0 immediately; following transfer completes normally.
